// File: rtl/byte_streamer_pkg.sv
// Shared constants and helpers for the byte_streamer serial-to-parallel deserializer.
package byte_streamer_pkg;

  localparam int BS_WIDTH = 8;

  function automatic int bs_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/byte_streamer_if.sv
// Serial input and parallel output bundle of the byte_streamer.
interface byte_streamer_if
  import byte_streamer_pkg::*;
#(
  parameter int WIDTH = BS_WIDTH
);

  logic             shift_enable;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_out;
  logic             byte_ready;

  modport master (
    output shift_enable,
    output serial_in,
    input  parallel_out,
    input  byte_ready
  );

  modport slave (
    input  shift_enable,
    input  serial_in,
    output parallel_out,
    output byte_ready
  );

endinterface

// File: rtl/byte_streamer_shift_reg.sv
// Enable-gated shift register; word_o is the value the register takes on an enabled edge.
module bs_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] word_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] shifted_s;

  generate
    if (WIDTH == 1) begin : g_single
      assign shifted_s = din;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted_s = {sr_q[WIDTH-2:0], din};
    end else begin : g_lsb
      assign shifted_s = {din, sr_q[WIDTH-1:1]};
    end
  endgenerate

  assign word_o = shifted_s;

  // Next-state: shift only on enabled edges.
  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d = shifted_s;
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/byte_streamer.sv
// MSB/LSB-first deserializer: counts enabled bits and publishes each completed word with a one-cycle strobe.
module byte_streamer
  import byte_streamer_pkg::*;
#(
  parameter int WIDTH     = BS_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  byte_streamer_if.slave bs
);

  // A one-bit counter is kept even for WIDTH=1 so the vector is never zero-width.
  localparam int              CNT_W    = (bs_cnt_w(WIDTH) > 0) ? bs_cnt_w(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] word_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rdy_q, rdy_d;

  bs_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bs.shift_enable),
    .din    (bs.serial_in),
    .word_o (word_s)
  );

  // Bit counting and word completion.
  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    rdy_d  = 1'b0;
    if (bs.shift_enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        dout_d = word_s;
        rdy_d  = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
    end
  end

  // Counter, output word and ready strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rdy_q  <= rdy_d;
    end
  end

  assign bs.parallel_out = dout_q;
  assign bs.byte_ready   = rdy_q;

endmodule

// File: tb/tb_byte_streamer.sv
// Scoreboard bench for byte_streamer: an MSB-first and an LSB-first instance share one bit stream.
module tb_byte_streamer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [2][$];
  logic [7:0] hold     [2];
  logic       prev_rdy [2];

  always #5 clk = ~clk;

  byte_streamer_if #(.WIDTH(8)) if_m ();
  byte_streamer_if #(.WIDTH(8)) if_l ();

  assign if_l.shift_enable = if_m.shift_enable;
  assign if_l.serial_in    = if_m.serial_in;

  byte_streamer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bs    (if_m)
  );

  byte_streamer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bs    (if_l)
  );

  task automatic drive(input logic en, input logic b);
    if_m.shift_enable = en;
    if_m.serial_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  // exp_msb: word seen by the MSB-first DUT; exp_lsb: hand-reversed word for the LSB-first DUT
  task automatic send_byte(input logic [7:0] exp_msb, input logic [7:0] exp_lsb);
    exp_q[0].push_back(exp_msb);
    exp_q[1].push_back(exp_lsb);
    for (int i = 7; i >= 0; i--) drive(1'b1, exp_msb[i]);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (if_m.parallel_out !== 8'h00 || if_m.byte_ready !== 1'b0 ||
        if_l.parallel_out !== 8'h00 || if_l.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: msb out=%h rdy=%b lsb out=%h rdy=%b, required out=00 rdy=0",
               name, if_m.parallel_out, if_m.byte_ready, if_l.parallel_out, if_l.byte_ready);
    end
  endtask

  initial begin
    hold[0] = 8'h00;
    hold[1] = 8'h00;
    prev_rdy[0] = 1'b0;
    prev_rdy[1] = 1'b0;
  end

  // Monitor: pop on every strobe, otherwise the output must hold its last word.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      logic       r;
      logic [7:0] p;
      logic [7:0] e;
      r = (c == 0) ? if_m.byte_ready   : if_l.byte_ready;
      p = (c == 0) ? if_m.parallel_out : if_l.parallel_out;
      if (r === 1'b1) begin
        checks++;
        if (prev_rdy[c] === 1'b1) begin
          errors++;
          $display("FAIL strobe_width ch%0d: byte_ready high in two consecutive cycles, required single pulse", c);
        end
        checks++;
        if (exp_q[c].size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready ch%0d: pulse with out=%h, required no pulse", c, p);
        end else begin
          e = exp_q[c].pop_front();
          hold[c] = e;
          if (p !== e) begin
            errors++;
            $display("FAIL word ch%0d: out=%h, required %h", c, p, e);
          end
        end
      end else begin
        checks++;
        if (p !== hold[c] || r !== 1'b0) begin
          errors++;
          $display("FAIL hold ch%0d: out=%h rdy=%b, required out=%h rdy=0", c, p, r, hold[c]);
        end
      end
      prev_rdy[c] = r;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    if_m.shift_enable = 1'b0;
    if_m.serial_in    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    for (int i = 0; i < 2; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_zero("reset_hold");
    rst_n = 1'b1;

    // Two separate bytes
    send_byte(8'hA5, 8'hA5);
    idle(2);
    send_byte(8'h3C, 8'h3C);
    idle(1);

    // Stall mid-byte with serial_in toggling
    exp_q[0].push_back(8'hC3);
    exp_q[1].push_back(8'hC3);
    drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'(i));
    drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
    idle(1);

    // Back-to-back
    send_byte(8'h12, 8'h48);
    send_byte(8'h34, 8'h2C);
    idle(2);

    // Reset mid-byte discards the partial word
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    #2;
    rst_n   = 1'b0;
    hold[0] = 8'h00;
    hold[1] = 8'h00;
    #1;
    check_zero("reset_mid");
    #3;
    rst_n = 1'b1;
    send_byte(8'h5A, 8'h5A);
    idle(1);

    // Order-sensitive words for the LSB-first instance
    send_byte(8'hA5, 8'hA5);
    send_byte(8'h80, 8'h01);
    idle(3);

    for (int c = 0; c < 2; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++;
        $display("FAIL missing_ready ch%0d: %0d words never strobed, required 0", c, exp_q[c].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
